// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the vending machine control unit
package vm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEP_CLR,
    DEP_LD,
    DEP_ACC,
    DEP_CHK,
    SEL_LD,
    SEL_RD,
    SEL_CHK,
    VEND,
    CLEAR,
    REFUND,
    PRG_LD,
    PRG_RD,
    PRG_WR
  } state_t;

  // Credit threshold above which the datapath flags an overpay refund
  localparam int REFUND_LIMIT = 501;

  // Idle cycles with stranded credit before it is handed back
  localparam int TIMEOUT_DEFAULT = 1000;

  // One bit per datapath strobe or panel event, decoded from the state
  typedef struct packed {
    logic ld_rdeposit;
    logic ld_rselect;
    logic ld_rprice;
    logic ld_rout;
    logic clr_r;
    logic clr_a;
    logic clr_rout;
    logic ld_a;
    logic ld_m;
    logic busy;
    logic vend;
    logic deny;
    logic cash_ret;
    logic prog_err;
  } ctl_t;

  // Counter width for a timeout, never narrower than one bit
  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/vm_timer.sv
// rtl/vm_timer.sv - saturating idle counter that flags when the credit timeout is reached
module vm_timer
  import vm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over count; the count parks at LAST so it can never wrap to 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/cu.sv
// rtl/cu.sv - vending machine control unit driving the du datapath strobes
module cu
  import vm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic coin,
  input  logic sel,
  input  logic cancel,
  input  logic prog,
  input  logic drop,
  input  logic refund,
  output logic ldRdeposit,
  output logic ldRselect,
  output logic ldRprice,
  output logic ldRout,
  output logic clrR,
  output logic clrA,
  output logic clrRout,
  output logic ldA,
  output logic ldM,
  output logic busy,
  output logic vend,
  output logic deny,
  output logic cash_ret,
  output logic prog_err
);

  state_t state_q;
  state_t state_d;
  logic   credit_q;
  logic   credit_d;
  logic   timer_clr;
  logic   timer_en;
  logic   timer_expire;
  ctl_t   ctl;

  // Timer runs only while parked in IDLE holding credit
  assign timer_en = (state_q == IDLE) && credit_q;

  vm_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(timer_expire)
  );

  // Next state, credit flag and timer reload; strobes only matter in IDLE
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    timer_clr = !credit_q;
    case (state_q)
      IDLE: begin
        if (prog && !credit_q) begin
          state_d   = PRG_LD;
          timer_clr = 1'b1;
        end else if (cancel && credit_q) begin
          state_d   = REFUND;
          timer_clr = 1'b1;
        end else if (coin) begin
          state_d   = credit_q ? DEP_LD : DEP_CLR;
          timer_clr = 1'b1;
        end else if (sel) begin
          state_d   = SEL_LD;
          timer_clr = 1'b1;
        end else if (credit_q && timer_expire) begin
          state_d = REFUND;
        end
      end
      DEP_CLR: state_d = DEP_LD;
      DEP_LD:  state_d = DEP_ACC;
      DEP_ACC: begin
        state_d  = DEP_CHK;
        credit_d = 1'b1;
      end
      DEP_CHK: state_d = refund ? REFUND : IDLE;
      SEL_LD:  state_d = SEL_RD;
      SEL_RD:  state_d = SEL_CHK;
      SEL_CHK: state_d = drop ? VEND : IDLE;
      VEND:    state_d = CLEAR;
      CLEAR: begin
        state_d  = IDLE;
        credit_d = 1'b0;
      end
      REFUND: begin
        state_d  = IDLE;
        credit_d = 1'b0;
      end
      PRG_LD:  state_d = PRG_RD;
      PRG_RD:  state_d = PRG_WR;
      PRG_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and credit registers; reset parks in IDLE with no credit
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  // Strobe decode from the state register; the two check states also look at drop
  always_comb begin
    ctl      = '0;
    ctl.busy = (state_q != IDLE);
    case (state_q)
      DEP_CLR: ctl.clr_rout    = 1'b1;
      DEP_LD:  ctl.ld_rdeposit = 1'b1;
      DEP_ACC: ctl.ld_a        = 1'b1;
      SEL_LD:  ctl.ld_rselect  = 1'b1;
      SEL_CHK: ctl.deny        = !drop;
      VEND: begin
        ctl.ld_m    = 1'b1;
        ctl.ld_rout = 1'b1;
        ctl.vend    = 1'b1;
      end
      CLEAR: begin
        ctl.clr_a = 1'b1;
        ctl.clr_r = 1'b1;
      end
      REFUND: begin
        ctl.clr_a    = 1'b1;
        ctl.clr_r    = 1'b1;
        ctl.cash_ret = 1'b1;
      end
      PRG_LD: begin
        ctl.ld_rselect = 1'b1;
        ctl.ld_rprice  = 1'b1;
      end
      // A zero credit that still covers the old price means the slot cannot be repriced safely
      PRG_WR: begin
        ctl.ld_m     = !drop;
        ctl.prog_err = drop;
      end
      default: ;
    endcase
  end

  // Everything is forced low while reset is held so no datapath strobe leaks out
  assign ldRdeposit = ctl.ld_rdeposit & rst;
  assign ldRselect  = ctl.ld_rselect & rst;
  assign ldRprice   = ctl.ld_rprice & rst;
  assign ldRout     = ctl.ld_rout & rst;
  assign clrR       = ctl.clr_r & rst;
  assign clrA       = ctl.clr_a & rst;
  assign clrRout    = ctl.clr_rout & rst;
  assign ldA        = ctl.ld_a & rst;
  assign ldM        = ctl.ld_m & rst;
  assign busy       = ctl.busy & rst;
  assign vend       = ctl.vend & rst;
  assign deny       = ctl.deny & rst;
  assign cash_ret   = ctl.cash_ret & rst;
  assign prog_err   = ctl.prog_err & rst;

endmodule

// File: tb/tb_cu.sv
// tb/tb_cu.sv - directed table-driven bench for cu with a small du datapath model
module tb_cu;
  import vm_pkg::*;

  localparam int TO = 20;

  localparam logic [13:0] B_LDRDEP  = 14'd1 << 13;
  localparam logic [13:0] B_LDRSEL  = 14'd1 << 12;
  localparam logic [13:0] B_LDRPRC  = 14'd1 << 11;
  localparam logic [13:0] B_LDROUT  = 14'd1 << 10;
  localparam logic [13:0] B_CLRR    = 14'd1 << 9;
  localparam logic [13:0] B_CLRA    = 14'd1 << 8;
  localparam logic [13:0] B_CLRROUT = 14'd1 << 7;
  localparam logic [13:0] B_LDA     = 14'd1 << 6;
  localparam logic [13:0] B_LDM     = 14'd1 << 5;
  localparam logic [13:0] B_BUSY    = 14'd1 << 4;
  localparam logic [13:0] B_VEND    = 14'd1 << 3;
  localparam logic [13:0] B_DENY    = 14'd1 << 2;
  localparam logic [13:0] B_CASH    = 14'd1 << 1;
  localparam logic [13:0] B_PERR    = 14'd1 << 0;

  localparam logic [13:0] E_IDLE = 14'd0;
  localparam logic [13:0] E_DCLR = B_CLRROUT | B_BUSY;
  localparam logic [13:0] E_DLD  = B_LDRDEP | B_BUSY;
  localparam logic [13:0] E_DACC = B_LDA | B_BUSY;
  localparam logic [13:0] E_WAIT = B_BUSY;
  localparam logic [13:0] E_SLD  = B_LDRSEL | B_BUSY;
  localparam logic [13:0] E_DENY = B_DENY | B_BUSY;
  localparam logic [13:0] E_VEND = B_LDM | B_LDROUT | B_VEND | B_BUSY;
  localparam logic [13:0] E_CLR  = B_CLRA | B_CLRR | B_BUSY;
  localparam logic [13:0] E_REF  = B_CLRA | B_CLRR | B_CASH | B_BUSY;
  localparam logic [13:0] E_PLD  = B_LDRSEL | B_LDRPRC | B_BUSY;
  localparam logic [13:0] E_PWR  = B_LDM | B_BUSY;
  localparam logic [13:0] E_PERR = B_PERR | B_BUSY;

  typedef struct {
    logic        coin;
    logic        sel;
    logic        cancel;
    logic        prog;
    int          dep;
    int          slot;
    int          price;
    logic [13:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin = 1'b0, sel = 1'b0, cancel = 1'b0, prog = 1'b0;
  logic drop, refund;
  logic ldRdeposit, ldRselect, ldRprice, ldRout, clrR, clrA, clrRout, ldA, ldM;
  logic busy, vend, deny, cash_ret, prog_err;
  logic [13:0] outv;

  int dep_bus = 0, sel_bus = 0, price_bus = 0;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  cu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel), .prog(prog),
    .drop(drop), .refund(refund),
    .ldRdeposit(ldRdeposit), .ldRselect(ldRselect), .ldRprice(ldRprice), .ldRout(ldRout),
    .clrR(clrR), .clrA(clrA), .clrRout(clrRout), .ldA(ldA), .ldM(ldM),
    .busy(busy), .vend(vend), .deny(deny), .cash_ret(cash_ret), .prog_err(prog_err)
  );

  assign outv = {ldRdeposit, ldRselect, ldRprice, ldRout, clrR, clrA, clrRout, ldA, ldM,
                 busy, vend, deny, cash_ret, prog_err};

  // du model: registers, accumulator, refund flag and a price/stock RAM with registered address
  int acc, r_dep, r_price, r_prod, r_bal;
  logic [2:0] r_sel, addr_q;
  logic refund_q, prog_mode;
  int price_m [8];
  int stock_m [8];

  always @(posedge clk) begin
    if (!rst) begin
      acc <= 0; r_dep <= 0; r_price <= 0; r_prod <= 0; r_bal <= 0;
      r_sel <= 0; addr_q <= 0; refund_q <= 0; prog_mode <= 0;
      if (n_total == 0) begin
        for (int i = 0; i < 8; i++) begin
          price_m[i] <= 100;
          stock_m[i] <= 3;
        end
        price_m[3] <= 250; stock_m[3] <= 2;
        price_m[5] <= 120; stock_m[5] <= 4;
        price_m[7] <= 0;   stock_m[7] <= 1;
      end
    end else begin
      addr_q <= r_sel;
      if (ldRdeposit) r_dep <= dep_bus;
      if (ldRselect) begin
        r_sel     <= 3'(sel_bus);
        prog_mode <= ldRprice;
      end
      if (ldRprice) r_price <= price_bus;
      if (ldA) begin
        acc      <= acc + r_dep;
        refund_q <= (acc >= REFUND_LIMIT);
      end
      if (clrA) acc <= 0;
      if (clrR) begin
        r_dep <= 0; r_sel <= 0; r_price <= 0; refund_q <= 0;
      end
      if (clrRout) begin
        r_prod <= 0; r_bal <= 0;
      end
      if (ldRout) begin
        r_prod <= int'(addr_q);
        r_bal  <= acc - price_m[addr_q];
      end
      if (ldM) begin
        if (prog_mode) price_m[addr_q] <= r_price;
        else           stock_m[addr_q] <= stock_m[addr_q] - 1;
      end
    end
  end

  assign drop   = (acc >= price_m[addr_q]) && (stock_m[addr_q] >= 1);
  assign refund = refund_q;

  function automatic vec_t mk(input logic c, input logic s, input logic x, input logic p,
                              input int d, input int sl, input int pr, input logic [13:0] e);
    vec_t v;
    v.coin = c; v.sel = s; v.cancel = x; v.prog = p;
    v.dep = d; v.slot = sl; v.price = pr; v.exp = e;
    return v;
  endfunction

  task automatic chk(input logic [13:0] got, input logic [13:0] exp, input string nm);
    n_total++;
    if (got !== exp) $display("FAIL %s: outputs got %b required %b", nm, got, exp);
    else n_pass++;
  endtask

  task automatic chk_int(input int got, input int exp, input string nm);
    n_total++;
    if (got != exp) $display("FAIL %s: got %0d required %0d", nm, got, exp);
    else n_pass++;
  endtask

  // Check this cycle's outputs, then drive the inputs sampled at the end of this cycle
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    chk(outv, v.exp, nm);
    coin = v.coin; sel = v.sel; cancel = v.cancel; prog = v.prog;
    if (v.coin) dep_bus = v.dep;
    if (v.sel || v.prog) begin
      sel_bus   = v.slot;
      price_bus = v.price;
    end
  endtask

  task automatic coin_seq(input int d, input bit first, input string nm);
    apply(mk(1, 0, 0, 0, d, 0, 0, E_IDLE), nm);
    if (first) apply(mk(0, 0, 0, 0, 0, 0, 0, E_DCLR), nm);
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_DLD), nm);
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_DACC), nm);
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), nm);
  endtask

  vec_t tbl [$];

  initial begin
    // coin 100 from zero credit, coin 200 with credit, select slot 3 -> vend
    tbl.push_back(mk(1, 0, 0, 0, 100, 0, 0, E_IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DCLR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DACC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(1, 0, 0, 0, 200, 0, 0, E_IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DACC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, E_IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_SLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_VEND));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_CLR));
    // coin 100, select slot 3 -> deny, credit kept
    tbl.push_back(mk(1, 0, 0, 0, 100, 0, 0, E_IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DCLR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DACC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, E_IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_SLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_DENY));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE));

    repeat (3) @(negedge clk);
    chk(outv, E_IDLE, "in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk(outv, E_IDLE, "after_reset");

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("tbl[%0d]", i));
      if (i == 14) begin
        chk_int(r_prod, 3, "vend_product");
        chk_int(r_bal, 50, "vend_balance");
        chk_int(stock_m[3], 1, "vend_stock");
      end
    end
    chk_int(acc, 100, "deny_credit_kept");

    // inactivity timeout: cash_ret TO cycles after the first idle cycle
    begin
      int n = 0;
      bit seen = 0;
      while (n < 3 * TO && !seen) begin
        @(negedge clk);
        n++;
        if (cash_ret) seen = 1;
      end
      chk_int(n, TO, "timeout_cycle");
      chk(outv, E_REF, "timeout_refund");
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "timeout_idle");
    chk_int(acc, 0, "timeout_acc");

    // cancel and coin together with credit -> refund wins
    coin_seq(100, 1, "cancel_coin_dep");
    apply(mk(1, 0, 1, 0, 50, 0, 0, E_IDLE), "cancel_coin_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_REF), "cancel_coin_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "cancel_coin_c2");
    chk_int(acc, 0, "cancel_acc");

    // program slot 5 with price 300 at zero credit
    apply(mk(0, 0, 0, 1, 0, 5, 300, E_IDLE), "prog_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PLD), "prog_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), "prog_c2");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PWR), "prog_c3");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "prog_c4");
    chk_int(price_m[5], 300, "prog_price5");

    // program slot 7 whose old price is 0 -> aborted, price unchanged
    apply(mk(0, 0, 0, 1, 0, 7, 90, E_IDLE), "perr_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PLD), "perr_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), "perr_c2");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PERR), "perr_c3");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "perr_c4");
    chk_int(price_m[7], 0, "perr_price7");

    // program with credit is ignored
    coin_seq(100, 1, "progcr_dep");
    apply(mk(0, 0, 0, 1, 0, 5, 999, E_IDLE), "progcr_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "progcr_c1");
    apply(mk(0, 0, 1, 0, 0, 0, 0, E_IDLE), "progcr_cancel");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_REF), "progcr_ref");
    chk_int(price_m[5], 300, "progcr_price5");

    // coins 300, 250, 10 -> third check sees refund
    coin_seq(300, 1, "ovp_300");
    coin_seq(250, 0, "ovp_250");
    apply(mk(1, 0, 0, 0, 10, 0, 0, E_IDLE), "ovp_10_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_DLD), "ovp_10_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_DACC), "ovp_10_c2");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), "ovp_10_c3");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_REF), "ovp_10_c4");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "ovp_10_c5");
    chk_int(acc, 0, "ovp_acc");

    // reset during SEL_RD
    coin_seq(100, 1, "rst_dep");
    apply(mk(0, 1, 0, 0, 0, 5, 0, E_IDLE), "rst_sel_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_SLD), "rst_sel_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), "rst_sel_c2");
    rst = 1'b0;
    @(negedge clk);
    chk(outv, E_IDLE, "rst_mid_outputs");
    rst = 1'b1;
    @(negedge clk);
    chk(outv, E_IDLE, "rst_mid_after");
    // credit must be gone: prog is honoured again
    apply(mk(0, 0, 0, 1, 0, 5, 400, E_IDLE), "rst_prog_c0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PLD), "rst_prog_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_WAIT), "rst_prog_c2");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_PWR), "rst_prog_c3");
    apply(mk(0, 0, 0, 0, 0, 0, 0, E_IDLE), "rst_prog_c4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cu.md
# cu

Control unit for the vending machine. Sits beside the `du` datapath and drives all of its register, accumulator and RAM strobes from user strobes (coin, select, cancel) and service strobes (program). It samples the datapath status flags `drop` and `refund`, runs an inactivity timeout that returns stranded credit, and emits one-cycle event pulses for the front panel.

## Interface
Parameters:
- `TIMEOUT`, 1000: idle cycles with nonzero credit before an automatic refund.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `coin`  in  1: deposit strobe; `du` deposit bus is valid in the same cycle.
- `sel`  in  1: selection strobe; `du` select bus is valid in the same cycle.
- `cancel`  in  1: customer refund request.
- `prog`  in  1: service write of a price; `du` select and price buses are valid.
- `drop`  in  1: from `du`. Credit covers the price and stock is at least 1.
- `refund`  in  1: from `du` refund register. Credit before the last coin was at least 501.
- `ldRdeposit`, `ldRselect`, `ldRprice`, `ldRout`, `clrR`, `clrA`, `clrRout`, `ldA`, `ldM`  out  1 each: `du` strobes.
- `busy`  out  1: state is not IDLE.
- `vend`  out  1: one-cycle pulse when a product is dispensed.
- `deny`  out  1: one-cycle pulse when a selection is rejected.
- `cash_ret`  out  1: one-cycle pulse when credit is returned.
- `prog_err`  out  1: one-cycle pulse when a price write is aborted.

## Operation
- All outputs are decoded from the state register (Moore). Every output is 0 while `rst`=0 and in the cycle after reset.
- An internal `credit` flag is set in DEP_ACC and cleared by every `clrA` state.
- Strobes are sampled only in IDLE and are ignored in all other states. No queueing.
- Priority in IDLE: `prog` (honoured only if `credit`=0, otherwise ignored) > `cancel` > `coin` > `sel`.
- IDLE transitions:
  - `cancel` with `credit`=1 → REFUND. `cancel` with `credit`=0 is ignored.
  - `coin` → DEP_CLR if `credit`=0, else DEP_LD.
  - `sel` → SEL_LD.
  - `prog` → PRG_LD.
  - Timer expiry → REFUND.
- Deposit path:
  - DEP_CLR: `clrRout`, which clears the previous product/balance. → DEP_LD.
  - DEP_LD: `ldRdeposit`. → DEP_ACC.
  - DEP_ACC: `ldA`. → DEP_CHK.
  - DEP_CHK: if `refund`=1 → REFUND, else → IDLE.
- Select path:
  - SEL_LD: `ldRselect`. → SEL_RD.
  - SEL_RD: no strobes; waits for the RAM read. → SEL_CHK.
  - SEL_CHK: if `drop`=1 → VEND, else `deny` → IDLE with credit retained.
- VEND: `ldM` (stock decrements) and `ldRout` (product and balance latched), plus `vend`. → CLEAR.
- CLEAR: `clrA` and `clrR`. → IDLE. The balance output is held until the next first coin.
- REFUND: `clrA`, `clrR`, `cash_ret`. → IDLE.
- Program path:
  - PRG_LD: `ldRselect` and `ldRprice`. → PRG_RD.
  - PRG_RD: no strobes. → PRG_WR.
  - PRG_WR: if `drop`=0, assert `ldM` (writes the price, keeps stock). If `drop`=1, no `ldM`, assert `prog_err` (a zero credit covers the old price). → IDLE.
- Timer:
  - Counts only in IDLE with `credit`=1.
  - Reloads to 0 on every accepted strobe and whenever `credit`=0.
  - Expires when count equals `TIMEOUT`-1.
  - Width is `$clog2(TIMEOUT)` bits and the count saturates, so it never wraps.
- Reset mid-operation: state returns to IDLE, the timer goes to 0 and `credit` goes to 0. No `du` strobe is issued in the reset cycle.

## Timing
- Cycle counts below have the strobe sampled in IDLE at cycle 0.
- Coin with `credit`=0: `clrRout` at c1, `ldRdeposit` at c2, `ldA` at c3, check at c4, back in IDLE at c5. With `credit`=1, each event is one cycle earlier.
- Select: `ldRselect` at c1. The RAM address registers at the end of c2, so `drop` is sampled at c3. VEND at c4, CLEAR at c5, IDLE at c6.
- Program: `ldM` at c3, IDLE at c4.
- `busy` is 1 from c1 until the return to IDLE.
- The controller never asserts `ldM` together with any `clr*` strobe.
- Simultaneous `clrR` and `ld*` strobes are never asserted.

## Structure
- Package `vm_pkg`:
  - state enum (IDLE, DEP_CLR, DEP_LD, DEP_ACC, DEP_CHK, SEL_LD, SEL_RD, SEL_CHK, VEND, CLEAR, REFUND, PRG_LD, PRG_RD, PRG_WR);
  - `REFUND_LIMIT` = 501;
  - `TIMEOUT` default.
- Sub-module `vm_timer`: a saturating idle counter with clear and enable inputs and an `expire` output.

## Test plan
- Reset, then a coin of 100 with `credit`=0 → `clrRout`, `ldRdeposit`, `ldA` at c1, c2, c3; `busy` low at c5.
- Coins 200 and 100, then select slot 3 (price 250, stock 2) → `vend` at c4 of the select; product = 3, balance = 50, stock = 1; `clrA` at c5.
- Credit 100, select slot 3 (price 250) → `deny` at c3, `ldM` never asserted, credit stays 100.
- Credit 100, no activity for `TIMEOUT` cycles → `cash_ret` in cycle `TIMEOUT`+1, accumulator = 0. `cancel` and `coin` asserted together with credit → REFUND wins.
- `prog` with slot 5 and price 300 at `credit`=0 → `ldM` at c3 and slot 5 reads back price 300. `prog` with credit nonzero → ignored, `busy` stays low.
- Coin sequence 300, 250, 10 → after the third coin DEP_CHK sees `refund`=1 and `cash_ret` pulses. Reset asserted in SEL_RD → all outputs 0 in the next cycle.
